// File: rtl/minisys_pkg.sv
// Shared MiniSys-1A encodings: load types, store byte-enable patterns,
// MEM-stage FSM states and the structures carried between MEM and WB.
package minisys_pkg;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } mem_state_e;

  typedef struct packed {
    logic        regwrite;
    logic        mem2reg;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        align_err;
    logic        bus_err;
  } memwb_t;

  // Everything the stage must remember while a bus access is outstanding.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  lt;
    logic        regwrite;
    logic        load;
    logic [4:0]  wreg;
    logic [31:0] alu;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the MEM stage: store lane shift/replication,
// misalignment detection, and little-endian load extraction/extension.
module mem_lane_align
  import minisys_pkg::*;
(
  input  logic [3:0]  memwrite_i,
  input  logic        mem2reg_i,
  input  logic [2:0]  loadtype_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] rdata_i,
  output logic        is_store_o,
  output logic        is_load_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_store_o = |memwrite_i;
    is_load_o  = mem2reg_i & ~is_store_o;
    misalign_o = 1'b0;
    be_o       = BE_W;
    wdata_o    = wdata_i;
    if (is_store_o) begin
      be_o = memwrite_i << addr_lo_i;
      case (memwrite_i)
        BE_B:    wdata_o = {4{wdata_i[7:0]}};
        BE_H: begin
          wdata_o    = {2{wdata_i[15:0]}};
          misalign_o = addr_lo_i[0];
        end
        BE_W:    misalign_o = (addr_lo_i != 2'b00);
        default: misalign_o = 1'b1;
      endcase
    end else if (is_load_o) begin
      case (loadtype_i)
        LT_LW:          misalign_o = (addr_lo_i != 2'b00);
        LT_LH, LT_LHU:  misalign_o = addr_lo_i[0];
        LT_LB, LT_LBU:  misalign_o = 1'b0;
        default:        misalign_o = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (ld_lo_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_type_i)
      LT_LB:   ldata_o = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU:  ldata_o = {24'd0, ld_byte};
      LT_LH:   ldata_o = {{16{ld_half[15]}}, ld_half};
      LT_LHU:  ldata_o = {16'd0, ld_half};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/minisys_mem_stage.sv
// MiniSys-1A MEM stage: data-bus master with wait-state FSM and timeout,
// producing the MEM/WB pipeline register and the branch-taken signal.
module minisys_mem_stage
  import minisys_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              regwriteM,
  input  logic              mem2regM,
  input  logic              branchM,
  input  logic              zeroM,
  input  logic [3:0]        memwriteM,
  input  logic [2:0]        loadtypeM,
  input  logic [31:0]       alu_outM,
  input  logic [31:0]       write_dataM,
  input  logic [4:0]        write_regM,
  output logic              pcsrcM,
  output logic              stallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic              regwriteW,
  output logic              mem2regW,
  output logic [4:0]        write_regW,
  output logic [31:0]       alu_outW,
  output logic [31:0]       read_dataW,
  output logic              align_errW,
  output logic              bus_errW
);

  localparam logic [31:0] TIMEOUT_CNT = TIMEOUT;

  mem_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  memwb_t      wb_q, wb_d;
  mem_req_t    req_q, req_live;

  logic        is_store, is_load, misalign;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ldata;
  logic        in_wait;

  assign in_wait = (state_q == S_WAIT);

  mem_lane_align u_align (
    .memwrite_i (memwriteM),
    .mem2reg_i  (mem2regM),
    .loadtype_i (loadtypeM),
    .addr_lo_i  (alu_outM[1:0]),
    .wdata_i    (write_dataM),
    .ld_type_i  (in_wait ? req_q.lt : loadtypeM),
    .ld_lo_i    (in_wait ? req_q.alu[1:0] : alu_outM[1:0]),
    .rdata_i    (dmem_rdata),
    .is_store_o (is_store),
    .is_load_o  (is_load),
    .misalign_o (misalign),
    .be_o       (st_be),
    .wdata_o    (st_wdata),
    .ldata_o    (ldata)
  );

  always_comb begin
    req_live.we       = is_store;
    req_live.be       = is_store ? st_be : BE_W;
    req_live.wdata    = is_store ? st_wdata : 32'd0;
    req_live.lt       = loadtypeM;
    req_live.regwrite = regwriteM;
    req_live.load     = is_load;
    req_live.wreg     = write_regM;
    req_live.alu      = alu_outM;
  end

  assign pcsrcM = branchM & zeroM;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_d       = '0;
    stallM     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_addr  = '0;
    dmem_wdata = 32'd0;
    case (state_q)
      S_IDLE: begin
        cnt_d         = 32'd0;
        wb_d.wreg     = write_regM;
        wb_d.alu      = alu_outM;
        if ((is_store || is_load) && misalign) begin
          wb_d.align_err = 1'b1;
        end else if (is_store || is_load) begin
          dmem_req   = 1'b1;
          dmem_we    = req_live.we;
          dmem_be    = req_live.be;
          dmem_addr  = {alu_outM[ADDR_W-1:2], 2'b00};
          dmem_wdata = req_live.wdata;
          if (dmem_ready) begin
            wb_d.regwrite = regwriteM;
            wb_d.mem2reg  = is_load;
            wb_d.rdata    = is_load ? ldata : 32'd0;
          end else begin
            stallM  = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 32'd1;
          end
        end else begin
          wb_d.regwrite = regwriteM;
        end
      end
      S_WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = req_q.we;
        dmem_be    = req_q.be;
        dmem_addr  = {req_q.alu[ADDR_W-1:2], 2'b00};
        dmem_wdata = req_q.wdata;
        if (dmem_ready) begin
          wb_d.regwrite = req_q.regwrite;
          wb_d.mem2reg  = req_q.load;
          wb_d.wreg     = req_q.wreg;
          wb_d.alu      = req_q.alu;
          wb_d.rdata    = req_q.load ? ldata : 32'd0;
          state_d       = S_IDLE;
          cnt_d         = 32'd0;
        end else if ((TIMEOUT > 0) && (cnt_q == TIMEOUT_CNT)) begin
          // Abandon the access: release the bus and let the pipeline move on.
          dmem_req     = 1'b0;
          dmem_we      = 1'b0;
          dmem_be      = 4'b0000;
          dmem_addr    = '0;
          dmem_wdata   = 32'd0;
          wb_d.bus_err = 1'b1;
          wb_d.wreg    = req_q.wreg;
          wb_d.alu     = req_q.alu;
          state_d      = S_IDLE;
          cnt_d        = 32'd0;
        end else begin
          stallM = 1'b1;
          cnt_d  = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      wb_q    <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      if (state_q == S_IDLE) begin
        req_q <= req_live;
      end
    end
  end

  assign regwriteW  = wb_q.regwrite;
  assign mem2regW   = wb_q.mem2reg;
  assign write_regW = wb_q.wreg;
  assign alu_outW   = wb_q.alu;
  assign read_dataW = wb_q.rdata;
  assign align_errW = wb_q.align_err;
  assign bus_errW   = wb_q.bus_err;

endmodule

// File: tb/tb_minisys_mem_stage.sv
// Directed self-checking bench for the MiniSys-1A MEM stage.
module tb_minisys_mem_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        regwriteM, mem2regM, branchM, zeroM;
  logic [3:0]  memwriteM;
  logic [2:0]  loadtypeM;
  logic [31:0] alu_outM, write_dataM;
  logic [4:0]  write_regM;
  logic        pcsrcM, stallM, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        regwriteW, mem2regW, align_errW, bus_errW;
  logic [4:0]  write_regW;
  logic [31:0] alu_outW, read_dataW;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  minisys_mem_stage #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk(clk), .clrn(clrn), .regwriteM(regwriteM), .mem2regM(mem2regM),
    .branchM(branchM), .zeroM(zeroM), .memwriteM(memwriteM), .loadtypeM(loadtypeM),
    .alu_outM(alu_outM), .write_dataM(write_dataM), .write_regM(write_regM),
    .pcsrcM(pcsrcM), .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .regwriteW(regwriteW),
    .mem2regW(mem2regW), .write_regW(write_regW), .alu_outW(alu_outW),
    .read_dataW(read_dataW), .align_errW(align_errW), .bus_errW(bus_errW)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one EX/MEM slot at the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic [3:0] mw, input logic m2r, input logic [2:0] lt,
                               input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                               input logic [4:0] wr, input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    memwriteM   = mw;
    mem2regM    = m2r;
    loadtypeM   = lt;
    alu_outM    = addr;
    write_dataM = wd;
    regwriteM   = rw;
    write_regM  = wr;
    dmem_ready  = rdy;
    dmem_rdata  = rd;
    branchM     = 1'b0;
    zeroM       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    memwriteM = 4'd0; mem2regM = 1'b0; loadtypeM = 3'd0; alu_outM = 32'd0;
    write_dataM = 32'd0; regwriteM = 1'b0; write_regM = 5'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0; branchM = 1'b0; zeroM = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_regwriteW", {31'd0, regwriteW}, 32'd0);
    checkOutput("reset_alu_outW", alu_outW, 32'd0);
    checkOutput("reset_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("reset_stall", {31'd0, stallM}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;

    // Non-memory instruction passes through in one cycle.
    applyStimulus(4'h0, 1'b0, 3'd0, 32'h77, 32'd0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF);
    tick();
    checkOutput("alu_regwriteW", {31'd0, regwriteW}, 32'd1);
    checkOutput("alu_alu_outW", alu_outW, 32'h77);
    checkOutput("alu_write_regW", {27'd0, write_regW}, 32'd3);
    checkOutput("alu_read_dataW", read_dataW, 32'd0);

    // Zero-wait sw.
    applyStimulus(4'hF, 1'b0, 3'd0, 32'h104, 32'hDEADBEEF, 1'b0, 5'd0, 1'b1, 32'd0);
    #1;
    checkOutput("sw_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("sw_we", {31'd0, dmem_we}, 32'd1);
    checkOutput("sw_be", {28'd0, dmem_be}, 32'hF);
    checkOutput("sw_addr", dmem_addr, 32'h104);
    checkOutput("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    checkOutput("sw_stall", {31'd0, stallM}, 32'd0);
    tick();
    checkOutput("sw_regwriteW", {31'd0, regwriteW}, 32'd0);
    checkOutput("sw_alu_outW", alu_outW, 32'h104);

    // sb to the top byte lane.
    applyStimulus(4'h1, 1'b0, 3'd0, 32'h103, 32'h0000_00A5, 1'b0, 5'd0, 1'b1, 32'd0);
    #1;
    checkOutput("sb_be", {28'd0, dmem_be}, 32'h8);
    checkOutput("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    checkOutput("sb_addr", dmem_addr, 32'h100);
    tick();
    checkOutput("sb_align", {31'd0, align_errW}, 32'd0);

    // lh / lhu from the upper halfword.
    applyStimulus(4'h0, 1'b1, 3'd3, 32'h102, 32'd0, 1'b1, 5'd5, 1'b1, 32'h8001_1234);
    #1;
    checkOutput("lh_we", {31'd0, dmem_we}, 32'd0);
    checkOutput("lh_be", {28'd0, dmem_be}, 32'hF);
    checkOutput("lh_addr", dmem_addr, 32'h100);
    tick();
    checkOutput("lh_regwriteW", {31'd0, regwriteW}, 32'd1);
    checkOutput("lh_mem2regW", {31'd0, mem2regW}, 32'd1);
    checkOutput("lh_read_dataW", read_dataW, 32'hFFFF8001);
    checkOutput("lh_write_regW", {27'd0, write_regW}, 32'd5);
    applyStimulus(4'h0, 1'b1, 3'd4, 32'h102, 32'd0, 1'b1, 5'd5, 1'b1, 32'h8001_1234);
    tick();
    checkOutput("lhu_read_dataW", read_dataW, 32'h00008001);

    // lb with three wait states; the live address changes but the bus must not.
    applyStimulus(4'h0, 1'b1, 3'd1, 32'h201, 32'd0, 1'b1, 5'd7, 1'b0, 32'h1234_8F00);
    #1;
    checkOutput("lbw_stall0", {31'd0, stallM}, 32'd1);
    checkOutput("lbw_addr0", dmem_addr, 32'h200);
    tick();
    checkOutput("lbw_bubble0", {31'd0, regwriteW}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      alu_outM = 32'h99A;
      #1;
      checkOutput("lbw_stall", {31'd0, stallM}, 32'd1);
      checkOutput("lbw_addr", dmem_addr, 32'h200);
      checkOutput("lbw_req", {31'd0, dmem_req}, 32'd1);
      tick();
      checkOutput("lbw_bubble", {31'd0, regwriteW}, 32'd0);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    checkOutput("lbw_done_stall", {31'd0, stallM}, 32'd0);
    checkOutput("lbw_done_addr", dmem_addr, 32'h200);
    tick();
    checkOutput("lbw_regwriteW", {31'd0, regwriteW}, 32'd1);
    checkOutput("lbw_read_dataW", read_dataW, 32'hFFFFFF8F);
    checkOutput("lbw_write_regW", {27'd0, write_regW}, 32'd7);
    checkOutput("lbw_alu_outW", alu_outW, 32'h201);

    // Misaligned lw.
    applyStimulus(4'h0, 1'b1, 3'd0, 32'h102, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
    #1;
    checkOutput("mis_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("mis_stall", {31'd0, stallM}, 32'd0);
    tick();
    checkOutput("mis_alignW", {31'd0, align_errW}, 32'd1);
    checkOutput("mis_regwriteW", {31'd0, regwriteW}, 32'd0);
    checkOutput("mis_mem2regW", {31'd0, mem2regW}, 32'd0);
    applyStimulus(4'h0, 1'b0, 3'd0, 32'h10, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    checkOutput("mis_align_clear", {31'd0, align_errW}, 32'd0);

    // Timeout after 16 stall cycles; a late ready afterwards is ignored.
    applyStimulus(4'h0, 1'b1, 3'd0, 32'h300, 32'd0, 1'b1, 5'd2, 1'b0, 32'd0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput("to_stall", {31'd0, stallM}, 32'd1);
      tick();
    end
    checkOutput("to_no_err_yet", {31'd0, bus_errW}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("to_stall_drop", {31'd0, stallM}, 32'd0);
    checkOutput("to_req_drop", {31'd0, dmem_req}, 32'd0);
    tick();
    checkOutput("to_bus_errW", {31'd0, bus_errW}, 32'd1);
    checkOutput("to_regwriteW", {31'd0, regwriteW}, 32'd0);
    applyStimulus(4'h0, 1'b0, 3'd0, 32'h40, 32'd0, 1'b0, 5'd0, 1'b1, 32'hCAFEF00D);
    #1;
    checkOutput("late_req", {31'd0, dmem_req}, 32'd0);
    tick();
    checkOutput("late_bus_err_clear", {31'd0, bus_errW}, 32'd0);
    checkOutput("late_read_dataW", read_dataW, 32'd0);
    checkOutput("late_mem2regW", {31'd0, mem2regW}, 32'd0);

    // Reset while waiting on the bus.
    applyStimulus(4'h0, 1'b1, 3'd0, 32'h400, 32'd0, 1'b1, 5'd4, 1'b0, 32'd0);
    tick();
    applyStimulus(4'h0, 1'b0, 3'd0, 32'h55, 32'd0, 1'b1, 5'd6, 1'b0, 32'd0);
    clrn = 1'b0;
    tick();
    checkOutput("rst_wait_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_wait_stall", {31'd0, stallM}, 32'd0);
    checkOutput("rst_wait_regwriteW", {31'd0, regwriteW}, 32'd0);
    checkOutput("rst_wait_alu_outW", alu_outW, 32'd0);
    checkOutput("rst_wait_write_regW", {27'd0, write_regW}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1111_2222;
    #1;
    checkOutput("rst_late_req", {31'd0, dmem_req}, 32'd0);
    tick();
    checkOutput("rst_after_regwriteW", {31'd0, regwriteW}, 32'd1);
    checkOutput("rst_after_alu_outW", alu_outW, 32'h55);
    checkOutput("rst_after_read_dataW", read_dataW, 32'd0);

    // Branch resolution is purely combinational.
    @(negedge clk);
    branchM = 1'b1;
    zeroM   = 1'b1;
    #1;
    checkOutput("pcsrc_taken", {31'd0, pcsrcM}, 32'd1);
    zeroM = 1'b0;
    #1;
    checkOutput("pcsrc_not_taken", {31'd0, pcsrcM}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/minisys_mem_stage.md
Name: minisys_mem_stage

Overview:
- MEM stage of the MiniSys-1A five-stage pipeline; consumes the EX/MEM register outputs of the execute stage and produces the MEM/WB register.
- Drives a ready/request data-memory bus with byte-lane alignment for stores, load extraction and extension, a wait-state FSM with stall and timeout, and branch resolution.
- Supports little-endian byte ordering.

Parameters:
TIMEOUT, 16, max wait cycles before a bus error is flagged; 0 disables the timeout
ADDR_W, 32, data address width

Ports:
clk  in  1  clock, all state on rising edge
clrn  in  1  reset, synchronous, active-low
regwriteM  in  1  register write enable from EX/MEM
mem2regM  in  1  load instruction
branchM  in  1  branch instruction
zeroM  in  1  ALU zero flag
memwriteM  in  4  store byte-enable pattern, low-justified: 0001 sb, 0011 sh, 1111 sw, 0000 no store
loadtypeM  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
alu_outM  in  32  effective address, or ALU result
write_dataM  in  32  store data (rt)
write_regM  in  5  destination register
pcsrcM  out  1  branchM & zeroM, combinational
stallM  out  1  freeze IF/ID/EX and EX/MEM while high
dmem_req  out  1  bus request
dmem_we  out  1  1 for store
dmem_be  out  4  byte lane enables
dmem_addr  out  ADDR_W  word address, low 2 bits forced 0
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid with dmem_ready
dmem_ready  in  1  access complete this cycle
regwriteW  out  1  MEM/WB register write enable
mem2regW  out  1  MEM/WB select read data
write_regW  out  5  MEM/WB destination register
alu_outW  out  32  MEM/WB ALU result
read_dataW  out  32  MEM/WB extended load data
align_errW  out  1  misaligned access flag, one cycle
bus_errW  out  1  timeout flag, one cycle

Behaviour:
- Reset (clrn=0 at edge): FSM goes to IDLE, wait counter=0, all MEM/WB outputs=0, dmem_req=0. Applies mid-WAIT: the request is dropped and a late dmem_ready is ignored.
- Access classification:
  - A store is memwriteM!=0.
  - A load is mem2regM=1 with memwriteM=0; a store takes precedence if both are set, and mem2regW is forced 0.
- Misalignment:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - memwriteM not in {0000, 0001, 0011, 1111}.
  - loadtypeM > 4 on a load.
  - Result: no dmem_req; the next MEM/WB has align_errW=1, regwriteW=0, mem2regW=0; no stall.
- Store lanes:
  - dmem_be = memwriteM << addr[1:0].
  - dmem_wdata = {4{wd[7:0]}} for sb, {2{wd[15:0]}} for sh, wd for sw.
- Load extract:
  - Select byte rdata[8*a+7:8*a] or halfword rdata[16*a[1]+15:16*a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - dmem_be is 1111 for all loads.
- FSM IDLE:
  - An aligned access raises dmem_req combinationally in the same cycle and latches addr/be/wdata/we/loadtype/ctrl into internal registers.
  - dmem_ready=1 in the same cycle: zero-wait completion; MEM/WB captures the result, stallM=0.
  - Otherwise go to WAIT with stallM=1 (combinational, the same cycle).
- FSM WAIT:
  - Bus signals come from the latched registers and stay stable; stallM=1; MEM/WB loads a bubble (regwriteW=0, mem2regW=0, errors 0) each cycle.
  - dmem_ready=1: MEM/WB captures the latched ctrl plus extracted rdata; go to IDLE; stallM=0 that cycle.
  - Counter reaches TIMEOUT (TIMEOUT>0): drop req, bus_errW=1, regwriteW=0, go to IDLE.
- Non-memory instruction: MEM/WB captures ctrl and alu_outM, read_dataW=0, latency 1.
- dmem_ready in IDLE without a req is ignored.
- pcsrcM comes from the live inputs and is unaffected by stall.

Decomposition:
- Shared package minisys_pkg holds:
  - The loadtype encodings (LT_LW=0, LT_LB=1, LT_LBU=2, LT_LH=3, LT_LHU=4).
  - Byte-enable constants BE_B=4'b0001, BE_H=4'b0011, BE_W=4'b1111.
  - FSM state encodings (S_IDLE, S_WAIT).
- Sub-module mem_lane_align (combinational): store lane shift/replicate, load extract/extend, and misalign detection.

Test Plan:
- Zero-wait sw: addr=0x104, wd=0xDEADBEEF, memwriteM=1111, ready held 1 -> same cycle req=1, be=1111, addr=0x104, wdata=0xDEADBEEF; stallM=0; next cycle regwriteW=0.
- sb at addr=0x103, wd=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; lh at addr=0x102 with rdata=0x8001xxxx -> read_dataW=0xFFFF8001; lhu gives 0x00008001.
- lb with 3 wait states: ready asserted on the 4th request cycle -> stallM high for exactly 3 cycles, addr stable, 3 bubble MEM/WB cycles, then regwriteW=1, read_dataW sign-extended.
- Misaligned lw at addr=0x102 -> dmem_req never asserted, align_errW=1 for one cycle, regwriteW=0, no stall.
- Timeout: ready held 0 with TIMEOUT=16 -> stall for 16 cycles, then bus_errW=1, req drops, FSM IDLE; a late ready is ignored.
- Reset in WAIT: clrn=0 for one edge -> req=0, stallM=0, all W outputs 0. Separately, branchM=1 with zeroM=1 -> pcsrcM=1 combinationally.
